// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit datapath / 48-bit instruction CPU:
// opcode enums, instruction field positions and disassembly name helpers.
package cpu_pkg;

  localparam int ROM_DEPTH = 65536;
  localparam int RAM_DEPTH = 65536;

  localparam int ALUOP_HI  = 47;
  localparam int ALUOP_LO  = 43;
  localparam int TARGET_HI = 42;
  localparam int TARGET_LO = 39;
  localparam int SRCA_HI   = 38;
  localparam int SRCA_LO   = 36;
  localparam int SRCB_HI   = 35;
  localparam int SRCB_LO   = 33;
  localparam int COND_HI   = 32;
  localparam int COND_LO   = 29;
  localparam int SETF_BIT  = 28;
  localparam int SPARE_HI  = 27;
  localparam int SPARE_LO  = 25;
  localparam int AMODE_BIT = 24;
  localparam int ADDR_HI   = 23;
  localparam int ADDR_LO   = 8;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;

  typedef enum logic [4:0] {
    ALU_ZERO, ALU_A, ALU_B, ALU_ADD, ALU_SUB, ALU_RSUB, ALU_ADC, ALU_SBC,
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOTA, ALU_NOTB, ALU_INCA, ALU_DECA,
    ALU_INCB, ALU_DECB
  } aluop_e;

  typedef enum logic [3:0] {
    T_REGA, T_REGB, T_REGC, T_REGD, T_MARLO, T_MARHI, T_UART, T_RAM,
    T_HALT, T_PCHITMP, T_PCLO, T_PC
  } target_e;

  typedef enum logic [2:0] {
    SA_REGA, SA_REGB, SA_REGC, SA_REGD, SA_MARLO, SA_MARHI, SA_UART, SA_ZERO
  } srca_e;

  typedef enum logic [2:0] {
    SB_REGA, SB_REGB, SB_REGC, SB_REGD, SB_MARLO, SB_MARHI, SB_IMMED, SB_RAM
  } srcb_e;

  typedef enum logic [3:0] {
    C_ALWAYS, C_C, C_Z, C_O, C_N, C_EQ, C_NE, C_GT, C_LT
  } cond_e;

  typedef struct packed {
    logic c;
    logic z;
    logic o;
    logic n;
    logic eq;
    logic gt;
    logic lt;
  } flags_t;

  // Codes outside an enum have no name; report them explicitly.
  function automatic string aluop_name(logic [4:0] code);
    aluop_e op;
    op = aluop_e'(code);
    return (code > 5'd16) ? "ALU_NONE" : op.name();
  endfunction

  function automatic string target_name(logic [3:0] code);
    target_e t;
    t = target_e'(code);
    return (code > 4'd11) ? "T_NONE" : t.name();
  endfunction

  function automatic string cond_name(logic [3:0] code);
    cond_e c;
    c = cond_e'(code);
    return (code > 4'd8) ? "C_NEVER" : c.name();
  endfunction

endpackage

// File: rtl/alu.sv
// 8-bit ALU: one shared adder/subtractor for all arithmetic ops, with
// logic and pass-through ops producing zero carry and overflow.
module alu
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic [4:0] op,
  output logic [7:0] result,
  output flags_t     flags
);

  logic [7:0] x;
  logic [7:0] y;
  logic       ci;
  logic       sub;
  logic       arith;
  logic [8:0] wide;

  // Arithmetic ops are mapped onto x +/- y +/- ci; bit 8 is carry or borrow.
  always_comb begin
    x      = a;
    y      = b;
    ci     = 1'b0;
    sub    = 1'b0;
    arith  = 1'b1;
    result = 8'h00;
    case (aluop_e'(op))
      ALU_ADD:  ;
      ALU_SUB:  sub = 1'b1;
      ALU_RSUB: begin x = b; y = a; sub = 1'b1; end
      ALU_ADC:  ci = cin;
      ALU_SBC:  begin ci = cin; sub = 1'b1; end
      ALU_INCA: y = 8'd1;
      ALU_DECA: begin y = 8'd1; sub = 1'b1; end
      ALU_INCB: begin x = b; y = 8'd1; end
      ALU_DECB: begin x = b; y = 8'd1; sub = 1'b1; end
      default:  arith = 1'b0;
    endcase

    wide = sub ? ({1'b0, x} - {1'b0, y} - {8'b0, ci})
               : ({1'b0, x} + {1'b0, y} + {8'b0, ci});

    if (arith) begin
      result = wide[7:0];
    end else begin
      case (aluop_e'(op))
        ALU_A:    result = a;
        ALU_B:    result = b;
        ALU_AND:  result = a & b;
        ALU_OR:   result = a | b;
        ALU_XOR:  result = a ^ b;
        ALU_NOTA: result = ~a;
        ALU_NOTB: result = ~b;
        default:  result = 8'h00;
      endcase
    end

    flags.c  = arith & wide[8];
    flags.o  = arith & (sub ? (x[7] != y[7]) : (x[7] == y[7])) & (wide[7] != x[7]);
    flags.z  = (result == 8'h00);
    flags.n  = result[7];
    flags.eq = (a == b);
    flags.gt = (a > b);
    flags.lt = (a < b);
  end

endmodule

// File: rtl/cpu.sv
// Single-cycle CPU: ROM fetch, decode, ALU, register/RAM writeback and PC
// update all commit on one rising edge of system_clk.
module cpu
  import cpu_pkg::*;
(
  input logic _RESET_SWITCH,
  input logic system_clk
);

  logic [47:0] rom [ROM_DEPTH];
  logic [7:0]  ram [RAM_DEPTH];

  logic [15:0] pc;
  logic [7:0]  rega, regb, regc, regd, marlo, marhi, uart, pchitmp;
  flags_t      flags;
  logic        halted;

  logic [47:0] instr;
  logic [4:0]  aluop;
  target_e     target;
  srca_e       srca;
  srcb_e       srcb;
  cond_e       cond;
  logic        setf_n;
  logic        amode;
  logic [15:0] addr;
  logic [15:0] ram_addr;
  logic [7:0]  immed;
  logic [7:0]  a_bus;
  logic [7:0]  b_bus;
  logic [7:0]  result;
  flags_t      alu_flags;
  logic        taken;
  logic        unused_spare;

  assign instr        = rom[pc];
  assign aluop        = instr[ALUOP_HI:ALUOP_LO];
  assign target       = target_e'(instr[TARGET_HI:TARGET_LO]);
  assign srca         = srca_e'(instr[SRCA_HI:SRCA_LO]);
  assign srcb         = srcb_e'(instr[SRCB_HI:SRCB_LO]);
  assign cond         = cond_e'(instr[COND_HI:COND_LO]);
  assign setf_n       = instr[SETF_BIT];
  assign amode        = instr[AMODE_BIT];
  assign addr         = instr[ADDR_HI:ADDR_LO];
  assign immed        = instr[IMM_HI:IMM_LO];
  assign unused_spare = ^instr[SPARE_HI:SPARE_LO];
  assign ram_addr     = amode ? addr : {marhi, marlo};

  always_comb begin
    case (srca)
      SA_REGA:  a_bus = rega;
      SA_REGB:  a_bus = regb;
      SA_REGC:  a_bus = regc;
      SA_REGD:  a_bus = regd;
      SA_MARLO: a_bus = marlo;
      SA_MARHI: a_bus = marhi;
      SA_UART:  a_bus = uart;
      default:  a_bus = 8'h00;
    endcase
  end

  // RAM reads are asynchronous, so a read-modify-write sees the old value.
  always_comb begin
    case (srcb)
      SB_REGA:  b_bus = rega;
      SB_REGB:  b_bus = regb;
      SB_REGC:  b_bus = regc;
      SB_REGD:  b_bus = regd;
      SB_MARLO: b_bus = marlo;
      SB_MARHI: b_bus = marhi;
      SB_IMMED: b_bus = immed;
      default:  b_bus = ram[ram_addr];
    endcase
  end

  always_comb begin
    case (cond)
      C_ALWAYS: taken = 1'b1;
      C_C:      taken = flags.c;
      C_Z:      taken = flags.z;
      C_O:      taken = flags.o;
      C_N:      taken = flags.n;
      C_EQ:     taken = flags.eq;
      C_NE:     taken = ~flags.eq;
      C_GT:     taken = flags.gt;
      C_LT:     taken = flags.lt;
      default:  taken = 1'b0;
    endcase
  end

  alu u_alu (
    .a      (a_bus),
    .b      (b_bus),
    .cin    (flags.c),
    .op     (aluop),
    .result (result),
    .flags  (alu_flags)
  );

  always_ff @(posedge system_clk) begin
    if (!_RESET_SWITCH) begin
      pc      <= 16'h0000;
      rega    <= 8'h00;
      regb    <= 8'h00;
      regc    <= 8'h00;
      regd    <= 8'h00;
      marlo   <= 8'h00;
      marhi   <= 8'h00;
      uart    <= 8'h00;
      pchitmp <= 8'h00;
      flags   <= '0;
      halted  <= 1'b0;
    end else if (!halted) begin
      pc <= pc + 16'd1;
      if (taken) begin
        if (!setf_n) flags <= alu_flags;
        case (target)
          T_REGA:    rega    <= result;
          T_REGB:    regb    <= result;
          T_REGC:    regc    <= result;
          T_REGD:    regd    <= result;
          T_MARLO:   marlo   <= result;
          T_MARHI:   marhi   <= result;
          T_UART:    uart    <= result;
          T_HALT:    begin halted <= 1'b1; pc <= pc; end
          T_PCHITMP: pchitmp <= result;
          T_PCLO:    pc <= {pc[15:8], result};
          T_PC:      pc <= {pchitmp, result};
          default:   ;
        endcase
      end
    end
  end

  // RAM contents survive reset; reset only blocks a write in flight.
  always_ff @(posedge system_clk) begin
    if (_RESET_SWITCH && !halted && taken && target == T_RAM)
      ram[ram_addr] <= result;
  end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: table-driven ALU vectors, directed program
// sequences, and a randomized program checked against an instruction-level model.
module tb_cpu;
  import cpu_pkg::*;

  logic system_clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cpu dut (
    ._RESET_SWITCH (rst_n),
    .system_clk    (system_clk)
  );

  always #5 system_clk = ~system_clk;

  // Instruction-level reference state.
  logic [47:0] m_rom [65536];
  logic [7:0]  m_ram [65536];
  logic [7:0]  m_reg [7];
  logic [7:0]  m_pchitmp;
  logic [15:0] m_pc;
  logic [6:0]  m_flags;
  bit          m_halted;

  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [6:0] flg;
  } alu_vec_t;

  alu_vec_t vecs [12];

  function automatic logic [47:0] mk(int op, int tgt, int sa, int sb, int cnd,
                                     int noset, int dir, int adr, int imm);
    logic [47:0] w;
    w        = '0;
    w[47:43] = op[4:0];
    w[42:39] = tgt[3:0];
    w[38:36] = sa[2:0];
    w[35:33] = sb[2:0];
    w[32:29] = cnd[3:0];
    w[28]    = noset[0];
    w[24]    = dir[0];
    w[23:8]  = adr[15:0];
    w[7:0]   = imm[7:0];
    return w;
  endfunction

  function automatic logic [47:0] ldImm(int tgt, int imm);
    return mk(2, tgt, 7, 6, 0, 1, 0, 0, imm);
  endfunction

  function automatic logic [47:0] haltWord();
    return mk(0, 8, 7, 7, 0, 1, 0, 0, 0);
  endfunction

  task automatic applyStimulus(int n);
    repeat (n) @(posedge system_clk);
    @(negedge system_clk);
  endtask

  task automatic checkOutput(string name, logic [15:0] actual, logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic holdReset();
    @(negedge system_clk);
    rst_n = 1'b0;
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge system_clk);
    @(negedge system_clk);
    rst_n = 1'b1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 7; i++) m_reg[i] = 8'h00;
    m_pchitmp = 8'h00;
    m_pc      = 16'h0000;
    m_flags   = 7'b0;
    m_halted  = 1'b0;
  endtask

  // Executes one instruction from the spec's rules using plain integer math.
  task automatic modelStep();
    logic [47:0] w;
    int          op, tgt, sa, sb, cnd, ua, ub, sia, sib, full, sfull;
    bit          noset, dir, arith, take, c, o;
    logic [15:0] adr, next_pc;
    logic [7:0]  imm, a, b, r;
    logic [6:0]  nf;
    if (m_halted) return;
    w     = m_rom[m_pc];
    op    = int'(w[47:43]);
    tgt   = int'(w[42:39]);
    sa    = int'(w[38:36]);
    sb    = int'(w[35:33]);
    cnd   = int'(w[32:29]);
    noset = w[28];
    dir   = w[24];
    imm   = w[7:0];
    adr   = dir ? w[23:8] : {m_reg[5], m_reg[4]};
    a     = (sa == 7) ? 8'h00 : m_reg[sa];
    b     = (sb == 6) ? imm : (sb == 7) ? m_ram[adr] : m_reg[sb];
    ua    = int'(a);
    ub    = int'(b);
    sia   = int'(signed'(a));
    sib   = int'(signed'(b));
    arith = 1'b1;
    full  = 0;
    sfull = 0;
    r     = 8'h00;
    case (op)
      3:  begin full = ua + ub;                sfull = sia + sib; end
      4:  begin full = ua - ub;                sfull = sia - sib; end
      5:  begin full = ub - ua;                sfull = sib - sia; end
      6:  begin full = ua + ub + m_flags[6];   sfull = sia + sib + m_flags[6]; end
      7:  begin full = ua - ub - m_flags[6];   sfull = sia - sib - m_flags[6]; end
      13: begin full = ua + 1;                 sfull = sia + 1; end
      14: begin full = ua - 1;                 sfull = sia - 1; end
      15: begin full = ub + 1;                 sfull = sib + 1; end
      16: begin full = ub - 1;                 sfull = sib - 1; end
      default: arith = 1'b0;
    endcase
    if (arith) r = full[7:0];
    else begin
      case (op)
        1:  r = a;
        2:  r = b;
        8:  r = a & b;
        9:  r = a | b;
        10: r = a ^ b;
        11: r = ~a;
        12: r = ~b;
        default: r = 8'h00;
      endcase
    end
    c  = arith && (full < 0 || full > 255);
    o  = arith && (sfull < -128 || sfull > 127);
    nf = {c, r == 8'h00, o, r[7], ua == ub, ua > ub, ua < ub};
    case (cnd)
      0: take = 1'b1;
      1: take = m_flags[6];
      2: take = m_flags[5];
      3: take = m_flags[4];
      4: take = m_flags[3];
      5: take = m_flags[2];
      6: take = !m_flags[2];
      7: take = m_flags[1];
      8: take = m_flags[0];
      default: take = 1'b0;
    endcase
    next_pc = m_pc + 16'd1;
    if (take) begin
      if (!noset) m_flags = nf;
      if (tgt <= 6) m_reg[tgt] = r;
      else if (tgt == 7) m_ram[adr] = r;
      else if (tgt == 8) begin m_halted = 1'b1; next_pc = m_pc; end
      else if (tgt == 9) m_pchitmp = r;
      else if (tgt == 10) next_pc = {m_pc[15:8], r};
      else if (tgt == 11) next_pc = {m_pchitmp, r};
    end
    m_pc = next_pc;
  endtask

  initial begin
    logic [63:0] rnd;
    logic [47:0] w;
    logic [6:0]  f;

    vecs[0]  = '{5'd3,  8'hFF, 8'h01, 8'h00, 7'b1100010};
    vecs[1]  = '{5'd3,  8'h7F, 8'h01, 8'h80, 7'b0011010};
    vecs[2]  = '{5'd4,  8'h01, 8'h02, 8'hFF, 7'b1001001};
    vecs[3]  = '{5'd5,  8'h10, 8'h30, 8'h20, 7'b0000001};
    vecs[4]  = '{5'd8,  8'hF0, 8'h3C, 8'h30, 7'b0000010};
    vecs[5]  = '{5'd10, 8'h55, 8'h55, 8'h00, 7'b0100100};
    vecs[6]  = '{5'd11, 8'h0F, 8'h00, 8'hF0, 7'b0001010};
    vecs[7]  = '{5'd14, 8'h80, 8'h00, 8'h7F, 7'b0010010};
    vecs[8]  = '{5'd15, 8'h00, 8'hFF, 8'h00, 7'b1100001};
    vecs[9]  = '{5'd20, 8'h12, 8'h34, 8'h00, 7'b0100001};
    vecs[10] = '{5'd4,  8'h80, 8'h01, 8'h7F, 7'b0010010};
    vecs[11] = '{5'd9,  8'h00, 8'h00, 8'h00, 7'b0100100};

    // Randomized program: a prefix seeds a small RAM window, the rest is random.
    rst_n = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      m_ram[i] = 8'h00;
      if (i < 16) begin
        w = mk(2, 7, 7, 6, 0, 1, 1, 16'hA000 + i, int'($urandom_range(0, 255)));
      end else begin
        rnd = {$urandom, $urandom};
        w = rnd[47:0];
        if (w[42:39] == 4'd8) w[42:39] = 4'd12;
        w[24]    = 1'b1;
        w[23:12] = 12'hA00;
      end
      m_rom[i]   = w;
      dut.rom[i] = w;
    end
    releaseReset();
    modelReset();
    checkOutput("reset_pc", dut.pc, 16'h0000);
    f = dut.flags;
    checkOutput("reset_flags", {9'b0, f}, 16'h0000);
    for (int cyc = 0; cyc < 600; cyc++) begin
      modelStep();
      applyStimulus(1);
      f = dut.flags;
      checkOutput($sformatf("rnd%0d_pc", cyc), dut.pc, m_pc);
      checkOutput($sformatf("rnd%0d_rega", cyc), {8'h0, dut.rega}, {8'h0, m_reg[0]});
      checkOutput($sformatf("rnd%0d_regb", cyc), {8'h0, dut.regb}, {8'h0, m_reg[1]});
      checkOutput($sformatf("rnd%0d_regc", cyc), {8'h0, dut.regc}, {8'h0, m_reg[2]});
      checkOutput($sformatf("rnd%0d_regd", cyc), {8'h0, dut.regd}, {8'h0, m_reg[3]});
      checkOutput($sformatf("rnd%0d_uart", cyc), {8'h0, dut.uart}, {8'h0, m_reg[6]});
      checkOutput($sformatf("rnd%0d_pchitmp", cyc), {8'h0, dut.pchitmp}, {8'h0, m_pchitmp});
      checkOutput($sformatf("rnd%0d_flags", cyc), {9'b0, f}, {9'b0, m_flags});
    end

    // Table-driven ALU vectors: load A, load B, op into regc with SET, halt.
    for (int i = 0; i < 12; i++) begin
      holdReset();
      dut.rom[0] = ldImm(0, int'(vecs[i].a));
      dut.rom[1] = ldImm(1, int'(vecs[i].b));
      dut.rom[2] = mk(int'(vecs[i].op), 2, 0, 1, 0, 0, 0, 0, 0);
      dut.rom[3] = haltWord();
      releaseReset();
      applyStimulus(5);
      f = dut.flags;
      checkOutput($sformatf("alu%0d_%s_res", i, aluop_name(vecs[i].op)), {8'h0, dut.regc}, {8'h0, vecs[i].res});
      checkOutput($sformatf("alu%0d_%s_flags", i, aluop_name(vecs[i].op)), {9'b0, f}, {9'b0, vecs[i].flg});
      checkOutput($sformatf("alu%0d_halt_pc", i), dut.pc, 16'h0003);
    end

    // Two immediate loads.
    holdReset();
    dut.rom[0] = ldImm(0, 1);
    dut.rom[1] = ldImm(1, 2);
    dut.rom[2] = haltWord();
    releaseReset();
    applyStimulus(2);
    checkOutput("imm_pc", dut.pc, 16'h0002);
    checkOutput("imm_rega", {8'h0, dut.rega}, 16'h0001);
    checkOutput("imm_regb", {8'h0, dut.regb}, 16'h0002);

    // Far jump loop between 0 and 1024.
    holdReset();
    dut.rom[0]    = ldImm(9, 8'h04);
    dut.rom[1]    = ldImm(11, 8'h00);
    dut.rom[1024] = ldImm(9, 8'h00);
    dut.rom[1025] = ldImm(11, 8'h00);
    releaseReset();
    applyStimulus(2);
    checkOutput("jmp_to_1024", dut.pc, 16'd1024);
    applyStimulus(2);
    checkOutput("jmp_to_0", dut.pc, 16'd0);
    applyStimulus(2);
    checkOutput("jmp_again_1024", dut.pc, 16'd1024);

    // Jump to 0xFFFF; a never-taken load there; PC wraps to 0.
    holdReset();
    dut.rom[0]      = ldImm(9, 8'hFF);
    dut.rom[1]      = ldImm(11, 8'hFF);
    dut.rom[16'hFFFF] = mk(2, 0, 7, 6, 9, 1, 0, 0, 7);
    releaseReset();
    applyStimulus(2);
    checkOutput("wrap_at_ffff", dut.pc, 16'hFFFF);
    applyStimulus(1);
    checkOutput("wrap_to_0", dut.pc, 16'h0000);
    checkOutput("cond_never_rega", {8'h0, dut.rega}, 16'h0000);

    // Carry/zero from 0xFF+1 with SET, then a Z-conditional pclo branch.
    holdReset();
    dut.rom[0]  = ldImm(0, 8'hFF);
    dut.rom[1]  = ldImm(1, 8'h01);
    dut.rom[2]  = mk(3, 2, 0, 1, 0, 0, 0, 0, 0);
    dut.rom[3]  = mk(2, 10, 7, 6, 2, 1, 0, 0, 8'h40);
    dut.rom[4]  = haltWord();
    dut.rom[64] = haltWord();
    releaseReset();
    applyStimulus(3);
    f = dut.flags;
    checkOutput("setf_regc", {8'h0, dut.regc}, 16'h0000);
    checkOutput("setf_flags", {9'b0, f}, {9'b0, 7'b1100010});
    applyStimulus(1);
    checkOutput("condz_pclo", dut.pc, 16'h0040);
    applyStimulus(2);
    checkOutput("halt_at_40", dut.pc, 16'h0040);

    // Same add with NOSET: the C-conditional branch falls through.
    holdReset();
    dut.rom[2] = mk(3, 2, 0, 1, 0, 1, 0, 0, 0);
    dut.rom[3] = mk(2, 10, 7, 6, 1, 1, 0, 0, 8'h40);
    releaseReset();
    applyStimulus(4);
    f = dut.flags;
    checkOutput("noset_pc", dut.pc, 16'h0004);
    checkOutput("noset_flags", {9'b0, f}, 16'h0000);
    checkOutput("noset_regc", {8'h0, dut.regc}, 16'h0000);

    // RAM by direct and register addressing, plus read-modify-write.
    holdReset();
    dut.rom[0] = mk(2, 7, 7, 6, 0, 1, 1, 16'h1234, 8'h5A);
    dut.rom[1] = mk(2, 0, 7, 7, 0, 1, 1, 16'h1234, 0);
    dut.rom[2] = ldImm(5, 8'h12);
    dut.rom[3] = ldImm(4, 8'h34);
    dut.rom[4] = mk(2, 1, 7, 7, 0, 1, 0, 0, 0);
    dut.rom[5] = mk(15, 7, 7, 7, 0, 1, 1, 16'h1234, 0);
    dut.rom[6] = mk(2, 2, 7, 7, 0, 1, 1, 16'h1234, 0);
    dut.rom[7] = haltWord();
    releaseReset();
    applyStimulus(2);
    checkOutput("ram_dir_rega", {8'h0, dut.rega}, 16'h005A);
    applyStimulus(3);
    checkOutput("ram_reg_regb", {8'h0, dut.regb}, 16'h005A);
    applyStimulus(2);
    checkOutput("ram_rmw_regc", {8'h0, dut.regc}, 16'h005B);
    checkOutput("ram_rmw_cell", {8'h0, dut.ram[16'h1234]}, 16'h005B);

    // Halt at 5 holds for 10 cycles; reset clears everything.
    holdReset();
    dut.rom[0] = ldImm(0, 8'h11);
    dut.rom[1] = ldImm(1, 8'h22);
    dut.rom[2] = ldImm(2, 8'h33);
    dut.rom[3] = ldImm(3, 8'h44);
    dut.rom[4] = ldImm(6, 8'h55);
    dut.rom[5] = haltWord();
    releaseReset();
    applyStimulus(6);
    checkOutput("halt_pc", dut.pc, 16'h0005);
    applyStimulus(10);
    checkOutput("halt_pc_held", dut.pc, 16'h0005);
    checkOutput("halt_rega_held", {8'h0, dut.rega}, 16'h0011);
    checkOutput("halt_uart_held", {8'h0, dut.uart}, 16'h0055);
    holdReset();
    applyStimulus(1);
    checkOutput("rst_pc", dut.pc, 16'h0000);
    checkOutput("rst_rega", {8'h0, dut.rega}, 16'h0000);
    checkOutput("rst_regb", {8'h0, dut.regb}, 16'h0000);
    checkOutput("rst_regc", {8'h0, dut.regc}, 16'h0000);
    checkOutput("rst_regd", {8'h0, dut.regd}, 16'h0000);
    checkOutput("rst_uart", {8'h0, dut.uart}, 16'h0000);
    checkOutput("rst_halted", {15'h0, dut.halted}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
